morse_blinker_fsm: RTL and testbench

Sequential stage directly downstream of the ASCII-to-Morse encoder. It accepts one encoded character (pattern, length, valid) per handshake and plays it on a single LED output using standard Morse timing: dot = 1 unit, dash = 3 units, 1-unit intra-character gap, optional 3-unit inter-character gap. The stage reports busy/done/error back to the character sequencer upstream.

---
 rtl/morse_pkg.sv | 11 +
 rtl/morse_unit_timer.sv | 27 ++
 rtl/morse_blinker_fsm.sv | 90 +++++++++
 tb/tb_morse_blinker_fsm.sv | 137 +++++++++++++
 4 files changed

// File: rtl/morse_pkg.sv
// morse_pkg: shared Morse widths, limits, FSM state type and default unit counts
package morse_pkg;
  localparam int PATTERN_W = 5;
  localparam int LEN_W = 3;
  localparam int MAX_LEN = 5;
  localparam int DOT_UNITS = 1;
  localparam int DEF_DASH_UNITS = 3;
  localparam int DEF_GAP_UNITS = 1;
  localparam int DEF_CHAR_GAP_UNITS = 3;
  typedef enum logic [1:0] {IDLE, ON, GAP, CHAR_GAP} state_t;
endpackage

// File: rtl/morse_unit_timer.sv
// morse_unit_timer: prescaler plus 2-bit unit counter; expire pulses on the last cycle of target units
// Ports: clk, clear (sync restart from zero), target (units, 1..3), expire (combinational, one cycle)
module morse_unit_timer #(
  parameter int CLKS_PER_UNIT = 12500000
) (
  input  logic       clk,
  input  logic       clear,
  input  logic [1:0] target,
  output logic       expire
);
  localparam int W = $clog2(CLKS_PER_UNIT);
  localparam logic [W-1:0] LAST = W'(CLKS_PER_UNIT - 1);
  logic [W-1:0] presc;
  logic [1:0] units;
  logic tick;
  assign tick = presc == LAST;
  assign expire = tick && units == target - 2'd1;
  always_ff @(posedge clk)
    if (clear) begin
      presc <= '0;
      units <= '0;
    end else if (tick) begin
      presc <= '0;
      units <= units + 2'd1;
    end else
      presc <= presc + 1'b1;
endmodule

// File: rtl/morse_blinker_fsm.sv
// morse_blinker_fsm: plays one latched Morse character on o_LED with standard unit timing
// Ports: i_Clk, i_Rst_L (sync, active-low), i_Start/i_Morse_Pattern/i_Morse_Length/i_Valid (character request),
//        o_LED (registered drive), o_Busy, o_Done (one-cycle), o_Err (one-cycle reject)
// Build option: MORSE_CHAR_GAP_EN adds the trailing inter-character gap before o_Done
module morse_blinker_fsm
  import morse_pkg::*;
#(
  parameter int CLKS_PER_UNIT = 12500000,
  parameter int DASH_UNITS = DEF_DASH_UNITS,
  parameter int GAP_UNITS = DEF_GAP_UNITS,
  parameter int CHAR_GAP_UNITS = DEF_CHAR_GAP_UNITS
) (
  input  logic                 i_Clk,
  input  logic                 i_Rst_L,
  input  logic                 i_Start,
  input  logic [PATTERN_W-1:0] i_Morse_Pattern,
  input  logic [LEN_W-1:0]     i_Morse_Length,
  input  logic                 i_Valid,
  output logic                 o_LED,
  output logic                 o_Busy,
  output logic                 o_Done,
  output logic                 o_Err
);
  state_t state;
  logic [PATTERN_W-1:0] pattern;
  logic [LEN_W-1:0] idx;
  logic [1:0] target;
  logic expire, accept, reject;
  assign accept = state == IDLE && i_Start && i_Valid && i_Morse_Length != '0 && i_Morse_Length <= LEN_W'(MAX_LEN);
  assign reject = state == IDLE && i_Start && !accept;
  always_comb
    target = state == ON  ? (pattern[idx] ? 2'(DASH_UNITS) : 2'(DOT_UNITS)) :
             state == GAP ? 2'(GAP_UNITS) : 2'(CHAR_GAP_UNITS);
  // the timer restarts on every state change, and is parked at zero while idle
  morse_unit_timer #(.CLKS_PER_UNIT(CLKS_PER_UNIT)) u_timer (
    .clk(i_Clk),
    .clear(!i_Rst_L || state == IDLE || expire),
    .target(target),
    .expire(expire)
  );
  always_ff @(posedge i_Clk)
    if (!i_Rst_L) begin
      state <= IDLE;
      pattern <= '0;
      idx <= '0;
      o_LED <= 1'b0;
      o_Busy <= 1'b0;
      o_Done <= 1'b0;
      o_Err <= 1'b0;
    end else begin
      o_Done <= 1'b0;
      o_Err <= reject;
      case (state)
        IDLE: if (accept) begin
          pattern <= i_Morse_Pattern;
          idx <= i_Morse_Length - 1'b1;
          state <= ON;
          o_LED <= 1'b1;
          o_Busy <= 1'b1;
        end
        ON: if (expire) begin
          o_LED <= 1'b0;
          if (idx != '0)
            state <= GAP;
          else begin
`ifdef MORSE_CHAR_GAP_EN
            state <= CHAR_GAP;
`else
            state <= IDLE;
            o_Busy <= 1'b0;
            o_Done <= 1'b1;
`endif
          end
        end
        GAP: if (expire) begin
          idx <= idx - 1'b1;
          state <= ON;
          o_LED <= 1'b1;
        end
`ifdef MORSE_CHAR_GAP_EN
        CHAR_GAP: if (expire) begin
          state <= IDLE;
          o_Busy <= 1'b0;
          o_Done <= 1'b1;
        end
`endif
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_morse_blinker_fsm.sv
// tb_morse_blinker_fsm: directed checks of Morse playback timing, rejects, busy-ignore, back-to-back and reset
module tb_morse_blinker_fsm;
  localparam int CPU = 4;
`ifdef MORSE_CHAR_GAP_EN
  localparam int CG = 3 * CPU;
  localparam int DONE_E = 17, DONE_A = 33, DONE_0 = 89;
`else
  localparam int CG = 0;
  localparam int DONE_E = 5, DONE_A = 21, DONE_0 = 77;
`endif
  logic i_Clk = 1'b0, i_Rst_L = 1'b0, i_Start = 1'b0, i_Valid = 1'b0;
  logic [4:0] pat = '0;
  logic [2:0] len = '0;
  logic o_LED, o_Busy, o_Done, o_Err;
  int checks = 0, errors = 0;
  int d;
  bit exp_led[128], exp_busy[128], exp_done[128];
  always #5 i_Clk = ~i_Clk;
  morse_blinker_fsm #(.CLKS_PER_UNIT(CPU)) dut (
    .i_Clk(i_Clk), .i_Rst_L(i_Rst_L), .i_Start(i_Start), .i_Morse_Pattern(pat),
    .i_Morse_Length(len), .i_Valid(i_Valid), .o_LED(o_LED), .o_Busy(o_Busy),
    .o_Done(o_Done), .o_Err(o_Err)
  );
  task automatic chk(input string tag, input int c, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cycle %0d observed=%b expected=%b", tag, c, obs, exp);
    end
  endtask
  task automatic chk_int(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  task automatic build(input logic [4:0] p, input int l, output int dc);
    int c = 1;
    for (int i = 0; i < 128; i++) begin
      exp_led[i] = 0; exp_busy[i] = 0; exp_done[i] = 0;
    end
    for (int i = l - 1; i >= 0; i--) begin
      for (int k = 0; k < (p[i] ? 3 * CPU : CPU); k++) begin
        exp_led[c] = 1; exp_busy[c] = 1; c++;
      end
      if (i > 0)
        for (int k = 0; k < CPU; k++) begin
          exp_busy[c] = 1; c++;
        end
    end
    for (int k = 0; k < CG; k++) begin
      exp_busy[c] = 1; c++;
    end
    exp_done[c] = 1;
    dc = c;
  endtask
  task automatic play(input string tag, input logic [4:0] p, input logic [2:0] l, input int inj, output int done_at);
    int dc;
    build(p, int'(l), dc);
    pat = p; len = l; i_Valid = 1'b1; i_Start = 1'b1;
    @(posedge i_Clk);
    #1 i_Start = 1'b0; pat = ~p; len = 3'd7; i_Valid = 1'b0;
    done_at = -1;
    for (int c = 1; c <= dc; c++) begin
      @(negedge i_Clk);
      chk({tag, " led"}, c, o_LED, exp_led[c]);
      chk({tag, " busy"}, c, o_Busy, exp_busy[c]);
      chk({tag, " done"}, c, o_Done, exp_done[c]);
      chk({tag, " err"}, c, o_Err, 1'b0);
      if (o_Done && done_at < 0) done_at = c;
      i_Start = (c == inj);
      if (c == inj) begin
        pat = 5'b11111; len = 3'd5; i_Valid = 1'b1;
      end
    end
  endtask
  task automatic rej(input string tag, input logic [4:0] p, input logic [2:0] l, input logic v);
    pat = p; len = l; i_Valid = v; i_Start = 1'b1;
    @(posedge i_Clk);
    #1 i_Start = 1'b0;
    @(negedge i_Clk);
    chk({tag, " err"}, 1, o_Err, 1'b1);
    chk({tag, " led"}, 1, o_LED, 1'b0);
    chk({tag, " busy"}, 1, o_Busy, 1'b0);
    @(negedge i_Clk);
    chk({tag, " err"}, 2, o_Err, 1'b0);
    chk({tag, " busy"}, 2, o_Busy, 1'b0);
  endtask
  initial begin
    repeat (3) @(posedge i_Clk);
    @(negedge i_Clk);
    chk("rst led", 0, o_LED, 1'b0);
    chk("rst busy", 0, o_Busy, 1'b0);
    chk("rst done", 0, o_Done, 1'b0);
    chk("rst err", 0, o_Err, 1'b0);
    i_Rst_L = 1'b1;
    play("E", 5'b00000, 3'd1, -1, d);
    chk_int("E done cycle", d, DONE_E);
    @(negedge i_Clk);
    play("A", 5'b00001, 3'd2, 6, d);
    chk_int("A done cycle", d, DONE_A);
    play("E chained", 5'b00000, 3'd1, -1, d);
    chk_int("E chained done cycle", d, DONE_E);
    @(negedge i_Clk);
    play("0", 5'b11111, 3'd5, -1, d);
    chk_int("0 done cycle", d, DONE_0);
    @(negedge i_Clk);
    rej("invalid", 5'b10101, 3'd5, 1'b0);
    rej("len0", 5'b00001, 3'd0, 1'b1);
    rej("len6", 5'b00001, 3'd6, 1'b1);
    build(5'b00001, 2, d);
    pat = 5'b00001; len = 3'd2; i_Valid = 1'b1; i_Start = 1'b1;
    @(posedge i_Clk);
    #1 i_Start = 1'b0; i_Valid = 1'b0;
    for (int c = 1; c <= 11; c++) begin
      @(negedge i_Clk);
      chk("A pre-reset led", c, o_LED, exp_led[c]);
    end
    i_Rst_L = 1'b0;
    @(negedge i_Clk);
    chk("mid reset led", 12, o_LED, 1'b0);
    chk("mid reset busy", 12, o_Busy, 1'b0);
    chk("mid reset done", 12, o_Done, 1'b0);
    i_Rst_L = 1'b1;
    for (int c = 13; c < 18; c++) begin
      @(negedge i_Clk);
      chk("post reset led", c, o_LED, 1'b0);
      chk("post reset busy", c, o_Busy, 1'b0);
      chk("post reset done", c, o_Done, 1'b0);
    end
    play("E after reset", 5'b00000, 3'd1, -1, d);
    chk_int("E after reset done cycle", d, DONE_E);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
